// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a FIFO read port (ren, rdata one cycle later) into a valid/ready stream
// through a 2-entry skid buffer, counting delivered words.
module fifo_stream_reader #(
  parameter int WIDTH     = 36,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 fifo_ren,
  input  logic [WIDTH-1:0]     fifo_rdata,
  input  logic                 fifo_empty,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] word_count
);
  logic [1:0]       cnt;
  logic             inflight;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;
  logic [1:0]       occ;
  logic             to_head;
  always_comb begin
    pop      = m_valid & m_ready;
    // occupancy the buffer will have next cycle, counting the word still in flight
    occ      = cnt + {1'b0, inflight} - {1'b0, pop};
    fifo_ren = rst_n & en & ~fifo_empty & ~occ[1];
    to_head  = (cnt == {1'b0, pop});
  end
  assign m_valid = (cnt != 2'd0);
  assign m_data  = head;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      inflight   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      word_count <= '0;
    end else begin
      cnt      <= occ;
      inflight <= fifo_ren;
      if (pop) head <= tail;
      // a captured word lands after any shift, so it overrides the head update above
      if (inflight && to_head) head <= fifo_rdata;
      if (inflight && !to_head) tail <= fifo_rdata;
      if (pop) word_count <= word_count + CNT_WIDTH'(1);
    end
  end
endmodule
